fcl_uart_bus_scheduler: RTL and testbench
=========================================

Name: fcl_uart_bus_scheduler

Overview:
Shares one half-duplex servo-bus UART (fcl_uart_bidir, 8N1, tri-state pin) between NUM_REQ requesters. Each transaction has three parts:
- Round-robin grant to one requester.
- Command bytes streamed into the UART transmitter one at a time, each waiting for tx done.
- Optional collection of a fixed-length response, guarded by a timeout, then a bus turnaround gap before the next grant.

The block sits between the servo-command engines and the UART instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_BITS, 8, UART byte width
LEN_WIDTH, 8, width of expected-response-length field
RX_TIMEOUT_CYCLES, 50000, max clocks from last tx done or last rx byte to next rx byte (1 ms at 50 MHz)
TURNAROUND_CYCLES, 100, idle clocks enforced after every transaction

Ports:
clk_in  in  1  clock
_reset_in  in  1  asynchronous active-low reset
req_in  in  NUM_REQ  transaction request per requester, level
req_tx_data_in  in  NUM_REQ*DATA_BITS  packed current command byte per requester
req_tx_last_in  in  NUM_REQ  current byte is last command byte
req_rsp_len_in  in  NUM_REQ*LEN_WIDTH  expected response bytes; 0 = no response
gnt_out  out  NUM_REQ  one-hot grant, held for whole transaction
req_tx_ack_out  out  NUM_REQ  1-cycle pulse: current byte consumed, present next
rsp_data_out  out  DATA_BITS  received byte, shared
rsp_valid_out  out  NUM_REQ  1-cycle pulse to granted requester with rsp_data_out
rsp_done_out  out  NUM_REQ  1-cycle pulse: transaction complete, all bytes received
rsp_timeout_out  out  NUM_REQ  1-cycle pulse: transaction ended by timeout
busy_out  out  1  not IDLE
uart_tx_data_out  out  DATA_BITS  to UART tx_data_in
uart_tx_send_out  out  1  to UART tx_data_send_in, 1-cycle pulse
uart_tx_done_in  in  1  from UART tx_done_out
uart_rx_data_in  in  DATA_BITS  from UART rx_data_out
uart_rx_valid_in  in  1  from UART rx_data_valid_out

Behaviour:
- Clock and reset: one clock clk_in; reset _reset_in is asynchronous, active-low. Reset drives all outputs to 0, state to IDLE, RR pointer to NUM_REQ-1, all counters to 0. Reset mid-transaction aborts silently: no done or timeout pulse, send deasserted at once.
- States: IDLE, SEND, WAIT_TX, RX, GAP.
- IDLE:
  - If any req_in is set, grant goes to the first set bit searching from pointer+1, wrapping modulo NUM_REQ.
  - The pointer is updated to the winner, gnt_out is registered, and the winner's req_rsp_len_in is latched into rem_len.
  - State goes to SEND. Latency from req to gnt_out is 1 clock.
- SEND (one cycle):
  - uart_tx_data_out is the granted requester's byte, registered.
  - uart_tx_send_out=1 and req_tx_ack_out[g]=1 in the same cycle.
  - req_tx_last_in[g] is latched into last_flag.
  - State goes to WAIT_TX.
- WAIT_TX: wait for uart_tx_done_in. On done:
  - If last_flag=0, go to SEND.
  - Else if rem_len=0, pulse rsp_done_out[g] and go to GAP.
  - Else load the timeout counter and go to RX.
- RX: each uart_rx_valid_in does three things: pulse rsp_valid_out[g] with the byte, decrement rem_len, and reload the timeout counter.
  - When rem_len reaches 0 on a byte, pulse rsp_done_out[g] in the same cycle as the last rsp_valid_out, then go to GAP.
  - If the counter expires (RX_TIMEOUT_CYCLES clocks with no byte), pulse rsp_timeout_out[g] and go to GAP.
  - If a byte and expiry coincide, the byte wins: it is accepted and the counter reloads.
- GAP: gnt_out is cleared and TURNAROUND_CYCLES idle clocks are counted, then state goes to IDLE. uart_rx_valid_in in GAP or IDLE is dropped.
- Requester rules:
  - req_in deassertion after grant is ignored; the transaction runs to completion.
  - The requester must drop req_in in the cycle after rsp_done or rsp_timeout, or it re-enters arbitration.
- Ack rule: the requester must present its next byte no later than the cycle after req_tx_ack_out. Data is sampled only in SEND.
- Widths and counters:
  - Counter widths use clogb2 of the parameter values.
  - rem_len never underflows because RX is left at 0.
  - The RR pointer wraps at NUM_REQ-1 to 0.

Decomposition:
- Shared package fcl_uart_pkg holds:
  - state encodings (3-bit);
  - the clogb2 function;
  - the default baud, clock and timeout constants shared with fcl_uart_bidir.
- One sub-module, fcl_rr_arbiter: a combinational one-hot round-robin pick from a request vector and pointer, parameterised by NUM_REQ. The pointer register stays in the scheduler.

Test Plan:
- Req0 alone, 3 command bytes (0xFF,0x01,0x5A, last on 0x5A), rsp_len=0 -> three send pulses each after the prior tx done, three acks, rsp_done_out[0] once; gnt low for exactly TURNAROUND_CYCLES afterwards.
- Req2, 1 byte 0x02, rsp_len=2, model returns 0xAA,0xBB -> rsp_valid_out[2] twice with those values; rsp_done_out[2] coincides with 0xBB.
- Req1, rsp_len=3, only one byte returned -> one rsp_valid, then rsp_timeout_out[1] exactly RX_TIMEOUT_CYCLES clocks after that byte; no rsp_done.
- req_in=4'b1111 held, single-byte commands -> grant order 0,1,2,3,0 after reset, with a turnaround gap between each.
- A byte arrives on the expiry clock -> the byte is accepted and no timeout occurs. A further stray byte in GAP -> no rsp_valid pulse.
- _reset_in asserted during WAIT_TX of a 4-byte command -> all outputs 0 at once, no done or timeout pulse; after release, a new request is granted starting from req0.

Source files
------------

// File: rtl/fcl_uart_pkg.sv
// Shared definitions for the servo-bus UART blocks: scheduler state encoding,
// width helper and the default clock/baud/timing constants.
package fcl_uart_pkg;

  localparam int DEFAULT_CLK_HZ            = 50_000_000;
  localparam int DEFAULT_BAUD              = 1_000_000;
  localparam int DEFAULT_BAUD_DIV          = DEFAULT_CLK_HZ / DEFAULT_BAUD;
  localparam int DEFAULT_RX_TIMEOUT_CYCLES = DEFAULT_CLK_HZ / 1000;
  localparam int DEFAULT_TURNAROUND_CYCLES = 100;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND    = 3'd1,
    ST_WAIT_TX = 3'd2,
    ST_RX      = 3'd3,
    ST_GAP     = 3'd4
  } sched_state_t;

  // Bits needed to index 'value' distinct items (minimum 1).
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fcl_rr_arbiter.sv
// Combinational round-robin pick: first set request after ptr, wrapping.
module fcl_rr_arbiter
  import fcl_uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = clogb2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   gnt_idx,
  output logic               any
);

  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = PTR_W'(idx);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fcl_uart_bus_scheduler.sv
// Time-shares one half-duplex servo-bus UART between NUM_REQ command engines:
// round-robin grant, byte-wise command streaming, timed response capture, turnaround gap.
module fcl_uart_bus_scheduler
  import fcl_uart_pkg::*;
#(
  parameter int NUM_REQ           = 4,
  parameter int DATA_BITS         = 8,
  parameter int LEN_WIDTH         = 8,
  parameter int RX_TIMEOUT_CYCLES = DEFAULT_RX_TIMEOUT_CYCLES,
  parameter int TURNAROUND_CYCLES = DEFAULT_TURNAROUND_CYCLES
) (
  input  logic                           clk_in,
  input  logic                           _reset_in,
  input  logic [NUM_REQ-1:0]             req_in,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_tx_data_in,
  input  logic [NUM_REQ-1:0]             req_tx_last_in,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]   req_rsp_len_in,
  output logic [NUM_REQ-1:0]             gnt_out,
  output logic [NUM_REQ-1:0]             req_tx_ack_out,
  output logic [DATA_BITS-1:0]           rsp_data_out,
  output logic [NUM_REQ-1:0]             rsp_valid_out,
  output logic [NUM_REQ-1:0]             rsp_done_out,
  output logic [NUM_REQ-1:0]             rsp_timeout_out,
  output logic                           busy_out,
  output logic [DATA_BITS-1:0]           uart_tx_data_out,
  output logic                           uart_tx_send_out,
  input  logic                           uart_tx_done_in,
  input  logic [DATA_BITS-1:0]           uart_rx_data_in,
  input  logic                           uart_rx_valid_in
);

  localparam int PTR_W = clogb2(NUM_REQ);
  localparam int TMO_W = clogb2(RX_TIMEOUT_CYCLES + 1);
  localparam int GAP_W = clogb2(TURNAROUND_CYCLES + 1);

  sched_state_t          state;
  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      gnt_idx;
  logic [LEN_WIDTH-1:0]  rem_len;
  logic                  last_flag;
  logic [TMO_W-1:0]      tmo_cnt;
  logic [GAP_W-1:0]      gap_cnt;

  logic [NUM_REQ-1:0]    arb_gnt;
  logic [PTR_W-1:0]      arb_idx;
  logic                  arb_any;

  fcl_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req     (req_in),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  assign busy_out = (state != ST_IDLE);

  always_ff @(posedge clk_in or negedge _reset_in) begin
    if (!_reset_in) begin
      state            <= ST_IDLE;
      rr_ptr           <= PTR_W'(NUM_REQ - 1);
      gnt_idx          <= '0;
      rem_len          <= '0;
      last_flag        <= 1'b0;
      tmo_cnt          <= '0;
      gap_cnt          <= '0;
      gnt_out          <= '0;
      req_tx_ack_out   <= '0;
      rsp_data_out     <= '0;
      rsp_valid_out    <= '0;
      rsp_done_out     <= '0;
      rsp_timeout_out  <= '0;
      uart_tx_data_out <= '0;
      uart_tx_send_out <= 1'b0;
    end else begin
      uart_tx_send_out <= 1'b0;
      req_tx_ack_out   <= '0;
      rsp_valid_out    <= '0;
      rsp_done_out     <= '0;
      rsp_timeout_out  <= '0;
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            rr_ptr  <= arb_idx;
            gnt_idx <= arb_idx;
            gnt_out <= arb_gnt;
            rem_len <= req_rsp_len_in[arb_idx*LEN_WIDTH +: LEN_WIDTH];
            state   <= ST_SEND;
          end
        end
        // Byte is sampled here; send/ack become visible together on the next cycle.
        ST_SEND: begin
          uart_tx_data_out <= req_tx_data_in[gnt_idx*DATA_BITS +: DATA_BITS];
          uart_tx_send_out <= 1'b1;
          req_tx_ack_out   <= gnt_out;
          last_flag        <= req_tx_last_in[gnt_idx];
          state            <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          if (uart_tx_done_in) begin
            if (!last_flag) begin
              state <= ST_SEND;
            end else if (rem_len == '0) begin
              rsp_done_out <= gnt_out;
              gap_cnt      <= '0;
              state        <= ST_GAP;
            end else begin
              tmo_cnt <= TMO_W'(RX_TIMEOUT_CYCLES);
              state   <= ST_RX;
            end
          end
        end
        // A byte on the expiry clock takes priority over the timeout.
        ST_RX: begin
          if (uart_rx_valid_in) begin
            rsp_valid_out <= gnt_out;
            rsp_data_out  <= uart_rx_data_in;
            rem_len       <= rem_len - LEN_WIDTH'(1);
            tmo_cnt       <= TMO_W'(RX_TIMEOUT_CYCLES);
            if (rem_len == LEN_WIDTH'(1)) begin
              rsp_done_out <= gnt_out;
              gap_cnt      <= '0;
              state        <= ST_GAP;
            end
          end else if (tmo_cnt == TMO_W'(1)) begin
            rsp_timeout_out <= gnt_out;
            gap_cnt         <= '0;
            state           <= ST_GAP;
          end else begin
            tmo_cnt <= tmo_cnt - TMO_W'(1);
          end
        end
        // Grant stays up for the done/timeout cycle, then the bus idles.
        ST_GAP: begin
          gnt_out <= '0;
          if (gap_cnt == GAP_W'(TURNAROUND_CYCLES - 1)) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fcl_uart_bus_scheduler.sv
// Directed bench for the UART bus scheduler with short timeout/turnaround settings.
module tb_fcl_uart_bus_scheduler;

  localparam int NR   = 4;
  localparam int TMO  = 40;
  localparam int TURN = 10;

  logic          clk_in = 1'b0;
  logic          _reset_in = 1'b0;
  logic [NR-1:0] req_in = '0;
  logic [31:0]   req_tx_data_in = '0;
  logic [NR-1:0] req_tx_last_in = '0;
  logic [31:0]   req_rsp_len_in = '0;
  logic [NR-1:0] gnt_out, req_tx_ack_out, rsp_valid_out, rsp_done_out, rsp_timeout_out;
  logic [7:0]    rsp_data_out, uart_tx_data_out;
  logic          busy_out, uart_tx_send_out;
  logic          uart_tx_done_in = 1'b0;
  logic [7:0]    uart_rx_data_in = '0;
  logic          uart_rx_valid_in = 1'b0;

  int checks = 0;
  int failures = 0;

  fcl_uart_bus_scheduler #(
    .NUM_REQ(NR), .DATA_BITS(8), .LEN_WIDTH(8),
    .RX_TIMEOUT_CYCLES(TMO), .TURNAROUND_CYCLES(TURN)
  ) dut (
    .clk_in(clk_in), ._reset_in(_reset_in), .req_in(req_in),
    .req_tx_data_in(req_tx_data_in), .req_tx_last_in(req_tx_last_in),
    .req_rsp_len_in(req_rsp_len_in), .gnt_out(gnt_out),
    .req_tx_ack_out(req_tx_ack_out), .rsp_data_out(rsp_data_out),
    .rsp_valid_out(rsp_valid_out), .rsp_done_out(rsp_done_out),
    .rsp_timeout_out(rsp_timeout_out), .busy_out(busy_out),
    .uart_tx_data_out(uart_tx_data_out), .uart_tx_send_out(uart_tx_send_out),
    .uart_tx_done_in(uart_tx_done_in), .uart_rx_data_in(uart_rx_data_in),
    .uart_rx_valid_in(uart_rx_valid_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 32'(gnt_out), 0);
    chk({tag, "_ack"}, 32'(req_tx_ack_out), 0);
    chk({tag, "_send"}, 32'(uart_tx_send_out), 0);
    chk({tag, "_txdata"}, 32'(uart_tx_data_out), 0);
    chk({tag, "_busy"}, 32'(busy_out), 0);
    chk({tag, "_flags"}, 32'({rsp_valid_out, rsp_done_out, rsp_timeout_out}), 0);
  endtask

  // Requester r streams n bytes (byte k at bytes[8k+:8]); UART done follows 3 clocks after send.
  task automatic run_cmd(input int r, input int n, input logic [31:0] bytes, input logic [7:0] len);
    req_tx_data_in[r*8 +: 8] = bytes[7:0];
    req_tx_last_in[r]        = (n == 1);
    req_rsp_len_in[r*8 +: 8] = len;
    req_in[r]                = 1'b1;
    tick(1);
    chk("gnt_latency", 32'(gnt_out), 32'(1) << r);
    req_in[r] = 1'b0;
    for (int k = 0; k < n; k++) begin
      tick(1);
      chk("tx_send", 32'(uart_tx_send_out), 1);
      chk("tx_data", 32'(uart_tx_data_out), 32'(bytes[8*k +: 8]));
      chk("tx_ack", 32'(req_tx_ack_out), 32'(1) << r);
      if (k + 1 < n) begin
        req_tx_data_in[r*8 +: 8] = bytes[8*(k+1) +: 8];
        req_tx_last_in[r]        = (k + 1 == n - 1);
      end
      tick(1);
      chk("send_pulse_width", 32'(uart_tx_send_out), 0);
      tick(1);
      uart_tx_done_in = 1'b1;
      tick(1);
      uart_tx_done_in = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int cnt;
    cnt = 0;
    while (busy_out && cnt < 500) begin
      tick(1);
      cnt++;
    end
    chk("reach_idle", 32'(busy_out), 0);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    uart_rx_data_in  = b;
    uart_rx_valid_in = 1'b1;
    tick(1);
    uart_rx_valid_in = 1'b0;
  endtask

  initial begin
    int low_cnt;
    logic [3:0] exp_order [5];

    // Reset state
    tick(3);
    chk_all_zero("reset");
    _reset_in = 1'b1;
    tick(2);
    chk("idle_no_req", 32'(gnt_out), 0);

    // Req0, three bytes, no response
    run_cmd(0, 3, 32'h005A01FF, 8'd0);
    chk("s1_done", 32'(rsp_done_out), 32'b0001);
    chk("s1_no_timeout", 32'(rsp_timeout_out), 0);
    tick(1);
    chk("s1_done_once", 32'(rsp_done_out), 0);
    chk("s1_gnt_cleared", 32'(gnt_out), 0);
    tick(TURN - 2);
    chk("s1_gap_busy", 32'(busy_out), 1);
    tick(1);
    chk("s1_gap_end", 32'(busy_out), 0);

    // Req2, one byte, two response bytes
    run_cmd(2, 1, 32'h02, 8'd2);
    chk("s2_rx_busy", 32'(busy_out), 1);
    chk("s2_no_early_done", 32'(rsp_done_out), 0);
    rx_byte(8'hAA);
    chk("s2_valid0", 32'(rsp_valid_out), 32'b0100);
    chk("s2_data0", 32'(rsp_data_out), 32'hAA);
    chk("s2_done0", 32'(rsp_done_out), 0);
    tick(3);
    rx_byte(8'hBB);
    chk("s2_valid1", 32'(rsp_valid_out), 32'b0100);
    chk("s2_data1", 32'(rsp_data_out), 32'hBB);
    chk("s2_done1", 32'(rsp_done_out), 32'b0100);
    wait_idle();

    // Req1, three expected, one delivered -> timeout TMO clocks after it
    run_cmd(1, 1, 32'h31, 8'd3);
    rx_byte(8'h33);
    chk("s3_valid", 32'(rsp_valid_out), 32'b0010);
    chk("s3_data", 32'(rsp_data_out), 32'h33);
    tick(TMO - 1);
    chk("s3_no_early_timeout", 32'(rsp_timeout_out), 0);
    tick(1);
    chk("s3_timeout", 32'(rsp_timeout_out), 32'b0010);
    chk("s3_no_done", 32'(rsp_done_out), 0);
    wait_idle();

    // Req3, byte on the expiry clock wins; stray byte in GAP dropped
    run_cmd(3, 1, 32'h03, 8'd2);
    tick(TMO - 1);
    chk("s5_pre_expiry", 32'(rsp_timeout_out), 0);
    rx_byte(8'h77);
    chk("s5_expiry_valid", 32'(rsp_valid_out), 32'b1000);
    chk("s5_expiry_data", 32'(rsp_data_out), 32'h77);
    chk("s5_expiry_no_timeout", 32'(rsp_timeout_out), 0);
    tick(TMO - 1);
    chk("s5_reloaded", 32'(rsp_timeout_out), 0);
    rx_byte(8'h88);
    chk("s5_valid2", 32'(rsp_valid_out), 32'b1000);
    chk("s5_done", 32'(rsp_done_out), 32'b1000);
    tick(2);
    rx_byte(8'h99);
    chk("s5_stray_dropped", 32'(rsp_valid_out), 0);
    wait_idle();

    // Reset during WAIT_TX of a 4-byte command from req1
    req_tx_data_in[15:8] = 8'h11;
    req_tx_last_in[1]    = 1'b0;
    req_rsp_len_in[15:8] = 8'd0;
    req_in[1]            = 1'b1;
    tick(1);
    chk("s6_gnt", 32'(gnt_out), 32'b0010);
    req_in[1] = 1'b0;
    tick(1);
    chk("s6_send", 32'(uart_tx_send_out), 1);
    tick(1);
    _reset_in = 1'b0;
    #1;
    chk_all_zero("s6_async_reset");
    tick(2);
    chk("s6_no_pulse", 32'({rsp_done_out, rsp_timeout_out}), 0);
    _reset_in = 1'b1;
    tick(1);

    // All requesters held: order 0,1,2,3,0 from reset, TURN low clocks between grants
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    req_tx_data_in = 32'h13121110;
    req_tx_last_in = 4'b1111;
    req_rsp_len_in = '0;
    req_in         = 4'b1111;
    tick(1);
    for (int t = 0; t < 5; t++) begin
      chk("rr_gnt", 32'(gnt_out), 32'(exp_order[t]));
      tick(1);
      chk("rr_tx_data", 32'(uart_tx_data_out), 32'h10 + 32'(t % 4));
      uart_tx_done_in = 1'b1;
      tick(1);
      uart_tx_done_in = 1'b0;
      chk("rr_done", 32'(rsp_done_out), 32'(exp_order[t]));
      if (t < 4) begin
        tick(1);
        low_cnt = 0;
        while (gnt_out == '0 && low_cnt < 100) begin
          low_cnt++;
          tick(1);
        end
        chk("rr_gap_len", 32'(low_cnt), TURN);
      end
    end
    req_in = '0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
